// File: rtl/lv_fault_pkg.sv
// Shared types and defaults for the LV fault controller.
package lv_fault_pkg;

    localparam int unsigned ERR_NUM_DEF   = 16;
    localparam int unsigned FLT_CNT_W_DEF = 4;
    localparam int unsigned RCV_CNT_W_DEF = 8;
    localparam int unsigned CTRL_FSM_ST_W = 3;

    typedef enum logic [CTRL_FSM_ST_W-1:0] {
        PWR_DWN_ST  = 3'd0,
        WAIT_ST     = 3'd1,
        NML_ST      = 3'd2,
        FAILSAFE_ST = 3'd3,
        FAULT_ST    = 3'd4,
        RECOVER_ST  = 3'd5,
        CFG_ST      = 3'd6
    } ctrl_st_e;

endpackage

// File: rtl/lv_err_filter.sv
// Single-channel persistence filter. Only built when LV_FLT_FILTER_EN is defined.
`ifdef LV_FLT_FILTER_EN
module lv_err_filter #(
    parameter int unsigned FLT_CNT_W = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_raw,
    input  logic                 i_mask,
    input  logic [FLT_CNT_W-1:0] i_thr,
    output logic                 o_flt
);

    logic [FLT_CNT_W-1:0] cnt_d, cnt_q;
    logic [FLT_CNT_W-1:0] thr_eff;
    logic                 flt_d, flt_q;

    // Count consecutive active cycles, saturating at the threshold (0 behaves as 1)
    always_comb begin
        thr_eff = (i_thr == '0) ? FLT_CNT_W'(1) : i_thr;
        cnt_d   = '0;
        flt_d   = 1'b0;
        if (i_raw && !i_mask) begin
            if (cnt_q >= thr_eff) begin
                cnt_d = cnt_q;
                flt_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
                flt_d = (cnt_d == thr_eff);
            end
        end
    end

    // Counter and filtered-level registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
            flt_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            flt_q <= flt_d;
        end
    end

    assign o_flt = flt_q;

endmodule
`endif

// File: rtl/lv_fault_ctrl.sv
// LV operating-mode controller with generic error vector, sticky status, first-error
// capture and timed recovery. Define LV_FLT_FILTER_EN to build per-channel persistence
// filters; otherwise errors are qualified combinationally and i_flt_thr is ignored.
module lv_fault_ctrl
    import lv_fault_pkg::*;
#(
    parameter int unsigned ERR_NUM   = ERR_NUM_DEF,
    parameter int unsigned FLT_CNT_W = FLT_CNT_W_DEF,
    parameter int unsigned RCV_CNT_W = RCV_CNT_W_DEF,
    parameter int unsigned ERR_IDX_W = $clog2(ERR_NUM)
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_pwr_on,
    input  logic [ERR_NUM-1:0]       i_err_raw,
    input  logic [ERR_NUM-1:0]       i_err_mask,
    input  logic [ERR_NUM-1:0]       i_err_fatal,
    input  logic [ERR_NUM-1:0]       i_err_clr,
    input  logic [FLT_CNT_W-1:0]     i_flt_thr,
    input  logic [RCV_CNT_W-1:0]     i_rcv_time,
    input  logic                     i_reg_nml_en,
    input  logic                     i_reg_cfg_en,
    input  logic                     i_io_fsenb_n,
    input  logic                     i_hv_intb_n,
    output logic [ERR_NUM-1:0]       o_err_sts,
    output logic [ERR_IDX_W-1:0]     o_first_err_idx,
    output logic                     o_pwm_en,
    output logic                     o_fsc_en,
    output logic                     o_intb_n,
    output logic [CTRL_FSM_ST_W-1:0] o_cur_st
);

    logic [ERR_NUM-1:0] flt;
`ifdef LV_FLT_FILTER_EN
    logic [ERR_NUM-1:0] flt_reg;

    for (genvar g = 0; g < ERR_NUM; g++) begin : g_flt
        lv_err_filter #(
            .FLT_CNT_W (FLT_CNT_W)
        ) u_flt (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_raw   (i_err_raw[g]),
            .i_mask  (i_err_mask[g]),
            .i_thr   (i_flt_thr),
            .o_flt   (flt_reg[g])
        );
    end
    // Mask also gates the registered level so masking takes effect immediately
    assign flt = flt_reg & ~i_err_mask;
`else
    logic unused_flt_thr;
    assign unused_flt_thr = ^i_flt_thr;
    assign flt = i_err_raw & ~i_err_mask;
`endif

    ctrl_st_e               st_d, st_q;
    logic [RCV_CNT_W-1:0]   tmr_d, tmr_q;
    logic [ERR_NUM-1:0]     sts_d, sts_q;
    logic [ERR_IDX_W-1:0]   idx_d, idx_q, low_idx;
    logic                   pwm_d, pwm_q, fsc_d, fsc_q, intb_d, intb_q;
    logic                   any_err, any_fatal, lv_intb_n;

    assign any_err   = |sts_q;
    assign any_fatal = |(sts_q & i_err_fatal);

    // Sticky status: a live error always beats a simultaneous clear
    always_comb begin
        sts_d = flt | (sts_q & ~i_err_clr);
    end

    // Lowest set status bit
    always_comb begin
        low_idx = '0;
        for (int i = int'(ERR_NUM) - 1; i >= 0; i--) begin
            if (sts_q[i]) low_idx = ERR_IDX_W'(i);
        end
    end

    // Next state, recovery timer, first-error capture and next-state-derived outputs
    always_comb begin
        st_d  = st_q;
        tmr_d = tmr_q;
        idx_d = idx_q;
        if (!i_pwr_on) begin
            st_d = PWR_DWN_ST;
        end else begin
            case (st_q)
                PWR_DWN_ST:  st_d = WAIT_ST;
                WAIT_ST: begin
                    if (i_reg_nml_en && !any_err) st_d = i_io_fsenb_n ? NML_ST : FAILSAFE_ST;
                end
                NML_ST: begin
                    if (i_reg_cfg_en)       st_d = CFG_ST;
                    else if (any_err)       st_d = FAULT_ST;
                    else if (!i_io_fsenb_n) st_d = FAILSAFE_ST;
                end
                FAILSAFE_ST: begin
                    if (any_fatal)         st_d = FAULT_ST;
                    else if (i_io_fsenb_n) st_d = NML_ST;
                end
                FAULT_ST: begin
                    if (i_reg_cfg_en) begin
                        st_d = CFG_ST;
                    end else if (!any_err) begin
                        st_d  = RECOVER_ST;
                        tmr_d = i_rcv_time;
                    end
                end
                RECOVER_ST: begin
                    if (any_err)              st_d = FAULT_ST;
                    else if (tmr_q == '0)     st_d = i_io_fsenb_n ? NML_ST : FAILSAFE_ST;
                    else                      tmr_d = tmr_q - 1'b1;
                end
                CFG_ST: begin
                    if (!i_reg_cfg_en) begin
                        if (any_err) st_d = FAULT_ST;
                        else         st_d = i_io_fsenb_n ? NML_ST : FAILSAFE_ST;
                    end
                end
                default:     st_d = PWR_DWN_ST;
            endcase
        end

        if (st_q == PWR_DWN_ST) begin
            idx_d = '0;
        end else if ((st_q == NML_ST || st_q == FAILSAFE_ST) && st_d == FAULT_ST) begin
            idx_d = low_idx;
        end

        pwm_d     = (st_d == NML_ST) || (st_d == FAULT_ST && !any_fatal);
        fsc_d     = (st_d == FAILSAFE_ST);
        lv_intb_n = !((st_d == PWR_DWN_ST) || (st_d == WAIT_ST) || (st_d == FAULT_ST) ||
                      (st_d == RECOVER_ST) || (st_d == CFG_ST && any_err));
        intb_d    = lv_intb_n & i_hv_intb_n;
    end

    // State and output registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            st_q   <= PWR_DWN_ST;
            tmr_q  <= '0;
            sts_q  <= '0;
            idx_q  <= '0;
            pwm_q  <= 1'b0;
            fsc_q  <= 1'b0;
            intb_q <= 1'b1;
        end else begin
            st_q   <= st_d;
            tmr_q  <= tmr_d;
            sts_q  <= sts_d;
            idx_q  <= idx_d;
            pwm_q  <= pwm_d;
            fsc_q  <= fsc_d;
            intb_q <= intb_d;
        end
    end

    assign o_err_sts       = sts_q;
    assign o_first_err_idx = idx_q;
    assign o_pwm_en        = pwm_q;
    assign o_fsc_en        = fsc_q;
    assign o_intb_n        = intb_q;
    assign o_cur_st        = st_q;

endmodule
